// File: rtl/hamming84_encoder.sv
// Hamming(8,4) encoder with BPSK soft-symbol mapping behind a 2-entry FIFO.
// Define ENC_ERR_INJECT_EN to enable per-message single-symbol sign corruption.
module hamming84_encoder #(
   parameter int AMP = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                m_valid,
   output logic                m_ready,
   input  logic [3:0]          m,
   output logic                r_valid,
   input  logic                r_ready,
   output logic signed [5:0]   r [0:7],
   output logic [15:0]         cw_count,
   input  logic                err_en,
   input  logic [2:0]          err_pos
);

   localparam logic signed [5:0] SYM_POS = 6'(AMP);
   localparam logic signed [5:0] SYM_NEG = -SYM_POS;

   // Bit i of the result is code bit c_i.
   function automatic logic [7:0] encode_bits(input logic [3:0] msg);
      logic [7:0] c;
      c[3:0] = msg;
      c[4]   = msg[0] ^ msg[1] ^ msg[2];
      c[5]   = msg[0] ^ msg[1] ^ msg[3];
      c[6]   = msg[1] ^ msg[2] ^ msg[3];
      c[7]   = msg[0] ^ msg[2] ^ msg[3];
      return c;
   endfunction

   function automatic logic signed [5:0] map_sym(input logic b);
      return b ? SYM_POS : SYM_NEG;
   endfunction

   logic [1:0] occ;
   logic [1:0] occ_next;
   logic       wr_ptr;
   logic       rd_ptr;
   logic       rd_next;
   logic [7:0] mem [0:1];

   logic       push_p0;
   logic       pop_p0;
   logic [7:0] inj_p0;
   logic [7:0] cw_p0;
   logic [7:0] head_p0;

   assign m_ready = (occ < 2'd2);
   assign r_valid = (occ != 2'd0);

   assign push_p0 = m_valid && m_ready;
   assign pop_p0  = r_valid && r_ready;

`ifdef ENC_ERR_INJECT_EN
   // Flipping a code bit is exactly a sign negation of its symbol.
   assign inj_p0 = err_en ? (8'b1 << err_pos) : 8'b0;
`else
   logic unused_err;
   assign unused_err = ^{err_en, err_pos};
   assign inj_p0     = 8'b0;
`endif

   assign cw_p0   = encode_bits(m) ^ inj_p0;
   assign rd_next = rd_ptr ^ pop_p0;

   always_comb begin
      occ_next = occ;
      if (push_p0 && !pop_p0)
         occ_next = occ + 2'd1;
      else if (pop_p0 && !push_p0)
         occ_next = occ - 2'd1;
   end

   // A word written this edge bypasses storage when it becomes the new head.
   assign head_p0 = (push_p0 && (rd_next == wr_ptr)) ? cw_p0 : mem[rd_next];

   // ---- stage p0 -> registered FIFO state and head output ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ      <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         cw_count <= 16'd0;
         for (int j = 0; j < 2; j++)
            mem[j] <= 8'd0;
         for (int i = 0; i < 8; i++)
            r[i] <= 6'sd0;
      end else begin
         occ <= occ_next;
         if (push_p0) begin
            mem[wr_ptr] <= cw_p0;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_p0) begin
            rd_ptr   <= rd_next;
            cw_count <= cw_count + 16'd1;
         end
         // r only moves when the head changes; an emptying pop leaves it as-is.
         if ((push_p0 || pop_p0) && (occ_next != 2'd0)) begin
            for (int i = 0; i < 8; i++)
               r[i] <= map_sym(head_p0[i]);
         end
      end
   end

endmodule

// File: tb/tb_hamming84_encoder.sv
// Randomized + directed bench for hamming84_encoder: driver predicts codewords into
// a queue, an independent monitor pops and compares whenever a codeword is consumed.
module tb_hamming84_encoder;

   localparam int AMP = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              m_valid;
   logic              m_ready;
   logic [3:0]        m;
   logic              r_valid;
   logic              r_ready;
   logic signed [5:0] r [0:7];
   logic [15:0]       cw_count;
   logic              err_en;
   logic [2:0]        err_pos;

   hamming84_encoder #(.AMP(AMP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m        (m),
      .r_valid  (r_valid),
      .r_ready  (r_ready),
      .r        (r),
      .cw_count (cw_count),
      .err_en   (err_en),
      .err_pos  (err_pos)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sym [8];
   } cw_t;

   cw_t         exp_q [$];
   int          last_sym [8];
   logic [15:0] exp_cnt;
   int          n_vec = 0;
   int          n_err = 0;

   // Reference: each code bit is the parity of a subset of message bits.
   function automatic cw_t model(input logic [3:0] msg, input logic e, input logic [2:0] p);
      cw_t  w;
      int   masks [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                          4'b0111, 4'b1011, 4'b1110, 4'b1101};
      for (int i = 0; i < 8; i++) begin
         int ones = 0;
         for (int k = 0; k < 4; k++)
            if (masks[i][k] && msg[k]) ones++;
         w.sym[i] = (ones % 2 == 1) ? AMP : -AMP;
      end
`ifdef ENC_ERR_INJECT_EN
      if (e) w.sym[p] = -w.sym[p];
`else
      if (e && p > 7) w.sym[0] = 0;
`endif
      return w;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compares DUT state against the scoreboard every cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_cnt = 16'd0;
         for (int i = 0; i < 8; i++) last_sym[i] = 0;
         check("rst_r_valid", int'(r_valid), 0);
         check("rst_m_ready", int'(m_ready), 1);
         check("rst_cw_count", int'(cw_count), 0);
      end else begin
         check("m_ready", int'(m_ready), int'(exp_q.size() < 2));
         check("r_valid", int'(r_valid), int'(exp_q.size() > 0));
         check("cw_count", int'(cw_count), int'(exp_cnt));
         for (int i = 0; i < 8; i++) begin
            if (exp_q.size() > 0)
               check($sformatf("r[%0d]", i), int'(r[i]), exp_q[0].sym[i]);
            else
               check($sformatf("r_hold[%0d]", i), int'(r[i]), last_sym[i]);
         end
         if (r_valid && r_ready && exp_q.size() > 0) begin
            cw_t w;
            w = exp_q.pop_front();
            for (int i = 0; i < 8; i++) last_sym[i] = w.sym[i];
            exp_cnt = exp_cnt + 16'd1;
         end
      end
   end

   // One clock of stimulus; records the expected codeword if the DUT accepts.
   task automatic cyc(input logic mv, input logic [3:0] mm, input logic rr,
                      input logic e, input logic [2:0] p, output logic acc);
      m_valid = mv;
      m       = mm;
      r_ready = rr;
      err_en  = e;
      err_pos = p;
      @(negedge clk);
      #1;
      acc = m_valid && m_ready;
      if (acc) exp_q.push_back(model(m, err_en, err_pos));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      m_valid = 1'b0;
      r_ready = 1'b0;
      err_en  = 1'b0;
      err_pos = 3'd0;
      m       = 4'd0;
      rst_n   = 1'b0;
      #1;
      check("rst_now_r_valid", int'(r_valid), 0);
      check("rst_now_m_ready", int'(m_ready), 1);
      check("rst_now_cw_count", int'(cw_count), 0);
      for (int i = 0; i < 8; i++)
         check($sformatf("rst_now_r[%0d]", i), int'(r[i]), 0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic acc;
      int   tries;
      rst_n   = 1'b1;
      m_valid = 1'b0;
      r_ready = 1'b0;
      m       = 4'd0;
      err_en  = 1'b0;
      err_pos = 3'd0;
      #2;
      do_reset();

      // Basic encode, then one pop
      cyc(1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, acc);
      check("first_accept", int'(acc), 1);
      cyc(1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, acc);
      cyc(1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, acc);
      check("cw_count_basic", int'(cw_count), 1);

      // Mixed patterns, r_ready high while empty is ignored
      cyc(1'b1, 4'b1011, 1'b1, 1'b0, 3'd0, acc);
      cyc(1'b1, 4'b1111, 1'b1, 1'b0, 3'd0, acc);
      cyc(1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, acc);
      cyc(1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, acc);
      check("cw_count_mixed", int'(cw_count), 3);

      // Backpressure
      do_reset();
      cyc(1'b1, 4'b0110, 1'b0, 1'b0, 3'd0, acc);
      cyc(1'b1, 4'b1001, 1'b0, 1'b0, 3'd0, acc);
      cyc(1'b1, 4'b0101, 1'b0, 1'b0, 3'd0, acc);
      check("bp_third_held", int'(acc), 0);
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 4) begin
         cyc(1'b1, 4'b0101, 1'b1, 1'b0, 3'd0, acc);
         tries++;
      end
      check("bp_third_accepted", int'(acc), 1);
      repeat (4) cyc(1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, acc);
      check("bp_cw_count", int'(cw_count), 3);

      // Streaming at occupancy 1
      do_reset();
      cyc(1'b1, 4'($urandom), 1'b0, 1'b0, 3'd0, acc);
      for (int k = 0; k < 10; k++)
         cyc(1'b1, 4'($urandom), 1'b1, 1'b0, 3'd0, acc);
      check("stream_cw_count", int'(cw_count), 10);
      check("stream_occ1", int'(r_valid && m_ready), 1);
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, acc);

      // Error injection, then reset with two entries buffered
      do_reset();
      cyc(1'b1, 4'b0000, 1'b0, 1'b1, 3'd3, acc);
      cyc(1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, acc);
      cyc(1'b1, 4'b0011, 1'b0, 1'b1, 3'd6, acc);
      cyc(1'b1, 4'b1100, 1'b0, 1'b0, 3'd0, acc);
      check("two_buffered", int'(m_ready), 0);
      do_reset();

      // Randomized traffic
      for (int k = 0; k < 400; k++)
         cyc(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), acc);
      repeat (3) cyc(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, acc);

      // Counter wrap
      force dut.cw_count = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      #1;
      release dut.cw_count;
      cyc(1'b1, 4'($urandom), 1'b0, 1'b0, 3'd0, acc);
      check("wrap_preload", int'(cw_count), 16'hFFFF);
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, acc);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, acc);
      check("wrap_cw_count", int'(cw_count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
